// File: rtl/gpio_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// gpio_wb_arbiter_if
//
// Purpose:
//   One single-beat Wishbone (classic) link. It carries the request from a
//   bus master towards a slave and the response coming back.
//
// Signals:
//   cyc    master -> slave  bus cycle in progress
//   stb    master -> slave  strobe, a valid access is presented
//   we     master -> slave  1 = write, 0 = read
//   sel    master -> slave  byte selects [3:0]
//   adr    master -> slave  byte address [31:0]
//   dat_w  master -> slave  write data [31:0]
//   dat_r  slave -> master  read data [31:0]
//   ack    slave -> master  access acknowledge
//
// Modports:
//   master  used by whatever drives the request (cyc/stb/...).
//   slave   used by whatever answers it (dat_r/ack).
// ---------------------------------------------------------------------------
interface gpio_wb_arbiter_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack
    );
endinterface

// File: rtl/gpio_wb_arbiter.sv
// ---------------------------------------------------------------------------
// gpio_wb_arbiter
//
// Purpose:
//   Shares the GPIO controller's Wishbone slave port between two masters:
//   m0 is the management SoC and m1 is the user project. Each request is
//   forwarded as one registered single-beat slave transaction. A request
//   that gets no slave acknowledge within TIMEOUT cycles is completed by
//   the arbiter. It returns ERR_DATA and sets a sticky per-master timeout
//   flag. This guarantees that every accepted request is acknowledged.
//
// Parameters:
//   TIMEOUT   slave cycles to wait for s.ack before a forced completion
//             (2..255)
//   RR_EN     1 = round-robin between contending masters,
//             0 = fixed priority with m0 first
//   ERR_DATA  read data returned on a forced (timeout) completion
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   resetn     asynchronous, active-low reset
//   m0, m1     Wishbone links from the two masters (slave side). The
//              fields map as: cyc/stb/we/sel/adr/dat_w = mx_*_i,
//              dat_r = mx_dat_o, ack = mx_ack_o (one-cycle pulse)
//   s          Wishbone link to the GPIO slave (master side). The fields
//              map as: cyc/stb/we/sel/adr/dat_w = s_*_o,
//              dat_r = s_dat_i, ack = s_ack_i
//   grant_o    one-hot current owner {m1, m0}; 00 while idle
//   timeout_o  sticky timeout flag per master {m1, m0}
//   err_clr_i  clears timeout_o; a timeout in the same cycle still sets
//              its own bit
//
// Timing with a slave that acks one cycle after seeing the strobe:
//   cycle 0 request, cycle 1 s.stb, cycle 2 s.ack, cycle 3 mx ack,
//   cycle 4 idle again and able to grant. This gives one transaction
//   every 4 cycles.
// ---------------------------------------------------------------------------
module gpio_wb_arbiter #(
    parameter int unsigned TIMEOUT  = 16,
    parameter bit          RR_EN    = 1'b1,
    parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              resetn,
    gpio_wb_arbiter_if.slave  m0,
    gpio_wb_arbiter_if.slave  m1,
    gpio_wb_arbiter_if.master s,
    output logic [1:0]        grant_o,
    output logic [1:0]        timeout_o,
    input  logic              err_clr_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Counter value on which the forced completion fires. The counter is
    // 0 in the first strobe cycle, so s.stb is high for exactly TIMEOUT
    // cycles at most.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q,   state_d;
    logic [7:0]  cnt_q,     cnt_d;
    logic        s_cyc_q,   s_cyc_d;
    logic        s_we_q,    s_we_d;
    logic [3:0]  s_sel_q,   s_sel_d;
    logic [31:0] s_adr_q,   s_adr_d;
    logic [31:0] s_dat_q,   s_dat_d;
    logic [31:0] m0_dat_q,  m0_dat_d;
    logic [31:0] m1_dat_q,  m1_dat_d;
    logic [1:0]  ack_q,     ack_d;
    logic [1:0]  grant_q,   grant_d;
    logic [1:0]  timeout_q, timeout_d;
    logic        last_q,    last_d;     // 1 = m1 owned the previous transaction
    logic        abandon_q, abandon_d;  // owner left the bus during this transaction

    logic [1:0]  req;
    logic        pick_m1;
    logic        owner_m1;
    logic        owner_cyc;
    logic        abandon_now;

    assign req       = {m1.cyc & m1.stb, m0.cyc & m0.stb};
    assign owner_m1  = grant_q[1];
    assign owner_cyc = owner_m1 ? m1.cyc : m0.cyc;

    // Once the owner drops cyc, its ack must stay suppressed even if it
    // raises cyc again before the slave answers.
    assign abandon_now = abandon_q | ~owner_cyc;

    // Owner selection. The last-owner register resets to m1, so m0 wins
    // the first contested round in round-robin mode.
    always_comb begin
        if (req == 2'b11) begin
            pick_m1 = RR_EN ? ~last_q : 1'b0;
        end else begin
            pick_m1 = req[1];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_cyc_d   = s_cyc_q;
        s_we_d    = s_we_q;
        s_sel_d   = s_sel_q;
        s_adr_d   = s_adr_q;
        s_dat_d   = s_dat_q;
        m0_dat_d  = m0_dat_q;
        m1_dat_d  = m1_dat_q;
        ack_d     = 2'b00;
        grant_d   = grant_q;
        timeout_d = timeout_q & ~{2{err_clr_i}};
        last_d    = last_q;
        abandon_d = abandon_q;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    if (pick_m1) begin
                        s_we_d  = m1.we;
                        s_sel_d = m1.sel;
                        s_adr_d = m1.adr;
                        s_dat_d = m1.dat_w;
                        grant_d = 2'b10;
                    end else begin
                        s_we_d  = m0.we;
                        s_sel_d = m0.sel;
                        s_adr_d = m0.adr;
                        s_dat_d = m0.dat_w;
                        grant_d = 2'b01;
                    end
                    s_cyc_d   = 1'b1;
                    cnt_d     = 8'd0;
                    abandon_d = 1'b0;
                    state_d   = BUSY;
                end
            end

            BUSY: begin
                abandon_d = abandon_now;
                if (s.ack) begin
                    s_cyc_d = 1'b0;
                    if (!abandon_now) begin
                        if (owner_m1) begin
                            m1_dat_d = s.dat_r;
                            ack_d    = 2'b10;
                        end else begin
                            m0_dat_d = s.dat_r;
                            ack_d    = 2'b01;
                        end
                    end
                    state_d = ACK;
                end else if (cnt_q == CNT_LAST) begin
                    // Forced completion. The flag is set even for an
                    // abandoned request, and it overrides a clear in the
                    // same cycle.
                    s_cyc_d = 1'b0;
                    if (!abandon_now) begin
                        if (owner_m1) begin
                            m1_dat_d = ERR_DATA;
                            ack_d    = 2'b10;
                        end else begin
                            m0_dat_d = ERR_DATA;
                            ack_d    = 2'b01;
                        end
                    end
                    if (owner_m1) begin
                        timeout_d[1] = 1'b1;
                    end else begin
                        timeout_d[0] = 1'b1;
                    end
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ACK: begin
                // Requests are not sampled here. A master that has not
                // yet dropped its strobe is therefore not granted again.
                last_d  = owner_m1;
                grant_d = 2'b00;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            s_cyc_q   <= 1'b0;
            s_we_q    <= 1'b0;
            s_sel_q   <= 4'd0;
            s_adr_q   <= 32'd0;
            s_dat_q   <= 32'd0;
            m0_dat_q  <= 32'd0;
            m1_dat_q  <= 32'd0;
            ack_q     <= 2'b00;
            grant_q   <= 2'b00;
            timeout_q <= 2'b00;
            last_q    <= 1'b1;
            abandon_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_cyc_q   <= s_cyc_d;
            s_we_q    <= s_we_d;
            s_sel_q   <= s_sel_d;
            s_adr_q   <= s_adr_d;
            s_dat_q   <= s_dat_d;
            m0_dat_q  <= m0_dat_d;
            m1_dat_q  <= m1_dat_d;
            ack_q     <= ack_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
            last_q    <= last_d;
            abandon_q <= abandon_d;
        end
    end

    assign s.cyc   = s_cyc_q;
    assign s.stb   = s_cyc_q;
    assign s.we    = s_we_q;
    assign s.sel   = s_sel_q;
    assign s.adr   = s_adr_q;
    assign s.dat_w = s_dat_q;

    assign m0.dat_r = m0_dat_q;
    assign m0.ack   = ack_q[0];
    assign m1.dat_r = m1_dat_q;
    assign m1.ack   = ack_q[1];

    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_gpio_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gpio_wb_arbiter
//
// Two arbiters share one set of master stimulus. dut_rr uses round-robin
// arbitration and dut_fp uses fixed priority. Each arbiter drives its own
// GPIO-like slave, which acks one cycle after seeing a strobe, but only
// inside the window 32'h2100_0000..32'h2100_000F. The expected results
// come from a transaction-level model kept in this bench: a word memory,
// the expected timeout flags, and the previous owner for round-robin.
// ---------------------------------------------------------------------------
module tb_gpio_wb_arbiter;

    localparam int unsigned TIMEOUT  = 16;
    localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic resetn;
    logic err_clr;

    always #5 clk = ~clk;

    // Shared master drive variables
    logic [1:0]  p_cyc;
    logic [1:0]  p_stb;
    logic [1:0]  p_we;
    logic [3:0]  p_sel [2];
    logic [31:0] p_adr [2];
    logic [31:0] p_dat [2];

    gpio_wb_arbiter_if rr_m0 ();
    gpio_wb_arbiter_if rr_m1 ();
    gpio_wb_arbiter_if rr_s ();
    gpio_wb_arbiter_if fp_m0 ();
    gpio_wb_arbiter_if fp_m1 ();
    gpio_wb_arbiter_if fp_s ();

    assign rr_m0.cyc = p_cyc[0];  assign rr_m0.stb = p_stb[0];  assign rr_m0.we = p_we[0];
    assign rr_m0.sel = p_sel[0];  assign rr_m0.adr = p_adr[0];  assign rr_m0.dat_w = p_dat[0];
    assign rr_m1.cyc = p_cyc[1];  assign rr_m1.stb = p_stb[1];  assign rr_m1.we = p_we[1];
    assign rr_m1.sel = p_sel[1];  assign rr_m1.adr = p_adr[1];  assign rr_m1.dat_w = p_dat[1];
    assign fp_m0.cyc = p_cyc[0];  assign fp_m0.stb = p_stb[0];  assign fp_m0.we = p_we[0];
    assign fp_m0.sel = p_sel[0];  assign fp_m0.adr = p_adr[0];  assign fp_m0.dat_w = p_dat[0];
    assign fp_m1.cyc = p_cyc[1];  assign fp_m1.stb = p_stb[1];  assign fp_m1.we = p_we[1];
    assign fp_m1.sel = p_sel[1];  assign fp_m1.adr = p_adr[1];  assign fp_m1.dat_w = p_dat[1];

    logic [1:0] rr_grant, rr_timeout, fp_grant, fp_timeout;
    logic [1:0] rr_ack, fp_ack;

    assign rr_ack = {rr_m1.ack, rr_m0.ack};
    assign fp_ack = {fp_m1.ack, fp_m0.ack};

    gpio_wb_arbiter #(.TIMEOUT(TIMEOUT), .RR_EN(1'b1), .ERR_DATA(ERR_DATA)) dut_rr (
        .clk(clk), .resetn(resetn), .m0(rr_m0), .m1(rr_m1), .s(rr_s),
        .grant_o(rr_grant), .timeout_o(rr_timeout), .err_clr_i(err_clr)
    );

    gpio_wb_arbiter #(.TIMEOUT(TIMEOUT), .RR_EN(1'b0), .ERR_DATA(ERR_DATA)) dut_fp (
        .clk(clk), .resetn(resetn), .m0(fp_m0), .m1(fp_m1), .s(fp_s),
        .grant_o(fp_grant), .timeout_o(fp_timeout), .err_clr_i(err_clr)
    );

    // GPIO-like slaves: registered ack one cycle after the strobe, and no
    // answer at all outside the window.
    logic        rr_sack, fp_sack;
    logic [31:0] rr_srd, fp_srd;
    logic [31:0] mem_rr [4];
    logic [31:0] mem_fp [4];

    assign rr_s.ack = rr_sack;  assign rr_s.dat_r = rr_srd;
    assign fp_s.ack = fp_sack;  assign fp_s.dat_r = fp_srd;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_sack <= 1'b0;
            rr_srd  <= '0;
            for (int i = 0; i < 4; i++) mem_rr[i] <= '0;
        end else begin
            rr_sack <= 1'b0;
            if (rr_s.cyc && rr_s.stb && !rr_sack && rr_s.adr[31:4] == 28'h2100000) begin
                rr_sack <= 1'b1;
                rr_srd  <= mem_rr[rr_s.adr[3:2]];
                if (rr_s.we)
                    for (int b = 0; b < 4; b++)
                        if (rr_s.sel[b]) mem_rr[rr_s.adr[3:2]][8*b +: 8] <= rr_s.dat_w[8*b +: 8];
            end
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fp_sack <= 1'b0;
            fp_srd  <= '0;
            for (int i = 0; i < 4; i++) mem_fp[i] <= '0;
        end else begin
            fp_sack <= 1'b0;
            if (fp_s.cyc && fp_s.stb && !fp_sack && fp_s.adr[31:4] == 28'h2100000) begin
                fp_sack <= 1'b1;
                fp_srd  <= mem_fp[fp_s.adr[3:2]];
                if (fp_s.we)
                    for (int b = 0; b < 4; b++)
                        if (fp_s.sel[b]) mem_fp[fp_s.adr[3:2]][8*b +: 8] <= fp_s.dat_w[8*b +: 8];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [4];
    logic [1:0]  exp_to;
    int          model_last;   // 1 = m1 owned the last completed round-robin transaction

    int nChecks = 0;
    int nErrors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int m, input logic req, input logic we, input logic [3:0] sel,
                                 input logic [31:0] adr, input logic [31:0] dat);
        p_cyc[m] = req;
        p_stb[m] = req;
        p_we[m]  = we;
        p_sel[m] = sel;
        p_adr[m] = adr;
        p_dat[m] = dat;
    endtask

    task automatic resetModel();
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        exp_to     = 2'b00;
        model_last = 1;
    endtask

    // One uncontested transaction on dut_rr. clrCycle > 0 pulses err_clr
    // in that cycle, counting the request cycle as 0.
    task automatic doSingle(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int clrCycle);
        logic        inWin;
        int          expLat, ackCycle, stbCycles;
        logic [31:0] expDat;
        logic [1:0]  expGrant, expTo;
        logic        otherSeen;
        inWin    = (adr[31:4] == 28'h2100000);
        expLat   = inWin ? 3 : int'(TIMEOUT) + 1;
        expDat   = inWin ? ref_mem[adr[3:2]] : ERR_DATA;
        expGrant = (m == 0) ? 2'b01 : 2'b10;
        expTo    = (clrCycle > 0) ? 2'b00 : exp_to;
        if (!inWin) expTo[m] = 1'b1;
        applyStimulus(m, 1'b1, we, sel, adr, dat);
        ackCycle  = -1;
        stbCycles = 0;
        otherSeen = 1'b0;
        for (int n = 1; n <= int'(TIMEOUT) + 8 && ackCycle < 0; n++) begin
            @(negedge clk);
            err_clr = (n == clrCycle);
            if (rr_s.stb) stbCycles++;
            if (n == 1) begin
                checkOutput("txn_grant", rr_grant, expGrant);
                checkOutput("txn_s_adr", rr_s.adr, adr);
                checkOutput("txn_s_we_sel", {rr_s.we, rr_s.sel}, {we, sel});
                if (we) checkOutput("txn_s_dat", rr_s.dat_w, dat);
            end
            if (rr_ack[1-m]) otherSeen = 1'b1;
            if (rr_ack[m]) ackCycle = n;
        end
        err_clr = 1'b0;
        checkOutput("txn_ack_cycle", ackCycle, expLat);
        checkOutput("txn_other_ack", otherSeen, 1'b0);
        checkOutput("txn_stb_low_at_ack", rr_s.stb, 1'b0);
        checkOutput("txn_timeout_flags", rr_timeout, expTo);
        if (!we) checkOutput("txn_rdata", (m == 0) ? rr_m0.dat_r : rr_m1.dat_r, expDat);
        if (!inWin) checkOutput("txn_stb_cycles", stbCycles, TIMEOUT);
        applyStimulus(m, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        if (we && inWin)
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[adr[3:2]][8*b +: 8] = dat[8*b +: 8];
        exp_to     = expTo;
        model_last = m;
        @(negedge clk);
        checkOutput("txn_idle_grant", rr_grant, 2'b00);
    endtask

    // Both masters read continuously. m0 drops out after dropAfter acks.
    // Checks owner order, ack exclusivity, spacing and read data on both
    // arbiters.
    task automatic doContested(input int total, input int dropAfter);
        logic [31:0] a0, a1;
        int rrAcks, fpAcks, rrPrev, fpPrev, rrExp, fpExp, rrLast;
        a0 = 32'h2100_0004;
        a1 = 32'h2100_0008;
        applyStimulus(0, 1'b1, 1'b0, 4'hF, a0, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 4'hF, a1, 32'h0);
        rrAcks = 0; fpAcks = 0; rrPrev = 0; fpPrev = 0; rrLast = model_last;
        for (int n = 1; n <= total * 4 + 12 && (rrAcks < total || fpAcks < total); n++) begin
            @(negedge clk);
            if (rr_ack != 2'b00) begin
                rrExp = (rrAcks < dropAfter) ? 1 - rrLast : 1;
                checkOutput("rr_ack_owner", rr_ack, (rrExp == 1) ? 2'b10 : 2'b01);
                checkOutput("rr_grant_owner", rr_grant, (rrExp == 1) ? 2'b10 : 2'b01);
                checkOutput("rr_ack_gap", n - rrPrev, (rrAcks == 0) ? 3 : 4);
                checkOutput("rr_rdata", (rrExp == 1) ? rr_m1.dat_r : rr_m0.dat_r,
                            (rrExp == 1) ? ref_mem[2] : ref_mem[1]);
                rrLast = rrExp;
                rrPrev = n;
                rrAcks++;
                if (rrAcks == dropAfter) applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            end
            if (fp_ack != 2'b00) begin
                fpExp = (fpAcks < dropAfter) ? 0 : 1;
                checkOutput("fp_ack_owner", fp_ack, (fpExp == 1) ? 2'b10 : 2'b01);
                checkOutput("fp_ack_gap", n - fpPrev, (fpAcks == 0) ? 3 : 4);
                checkOutput("fp_rdata", (fpExp == 1) ? fp_m1.dat_r : fp_m0.dat_r,
                            (fpExp == 1) ? ref_mem[2] : ref_mem[1]);
                fpPrev = n;
                fpAcks++;
            end
            if (rrAcks >= total) begin
                applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
                applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            end
        end
        checkOutput("rr_ack_count", rrAcks, total);
        checkOutput("fp_ack_count", fpAcks, total);
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        model_last = rrLast;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a, d;
        int          stbCnt;
        logic        ackSeen;

        resetn  = 1'b0;
        err_clr = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        resetModel();

        // Reset values
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_s_ctrl", {rr_s.cyc, rr_s.stb, rr_s.we, rr_s.sel}, '0);
        checkOutput("rst_s_adr_dat", {rr_s.adr, rr_s.dat_w}, '0);
        checkOutput("rst_grant_timeout", {rr_grant, rr_timeout}, '0);
        checkOutput("rst_acks", {rr_ack, fp_ack}, '0);
        checkOutput("rst_m_dat", {rr_m0.dat_r, rr_m1.dat_r}, '0);
        resetn = 1'b1;

        // m0 writes 1 to the pin register, then reads it back
        doSingle(0, 1'b1, 32'h2100_0004, 32'h0000_0001, 4'hF, 0);
        doSingle(0, 1'b0, 32'h2100_0004, 32'h0, 4'hF, 0);
        checkOutput("pin_readback", rr_m0.dat_r, 32'h0000_0001);

        // Random uncontested accesses inside the window
        for (int k = 0; k < 8; k++) begin
            a = 32'h2100_0000 + 32'($urandom_range(0, 3) * 4);
            doSingle(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                     4'($urandom_range(1, 15)), 0);
        end

        // Continuous contention; m0 leaves after four acks
        doContested(6, 4);

        // Timeout: m1 reads outside the window, then clear
        doSingle(1, 1'b0, 32'h2200_0000, 32'h0, 4'hF, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_to  = 2'b00;
        checkOutput("err_clr", rr_timeout, exp_to);

        // A timeout in the same cycle as err_clr keeps its own bit
        doSingle(1, 1'b0, 32'h2200_0000, 32'h0, 4'hF, 0);
        doSingle(0, 1'b0, 32'h2200_0010, 32'h0, 4'hF, int'(TIMEOUT));

        // m0 abandons a write in the cycle after its grant
        a = 32'h2100_000C;
        d = $urandom;
        applyStimulus(0, 1'b1, 1'b1, 4'hF, a, d);
        @(negedge clk);
        checkOutput("abn_grant", rr_grant, 2'b01);
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        stbCnt  = 0;
        ackSeen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (rr_s.stb) stbCnt++;
            if (rr_ack != 2'b00) ackSeen = 1'b1;
            @(negedge clk);
        end
        checkOutput("abn_stb_cycles", stbCnt, 2);
        checkOutput("abn_no_ack", ackSeen, 1'b0);
        checkOutput("abn_idle", {rr_grant, rr_timeout}, {2'b00, exp_to});
        ref_mem[3] = d;
        model_last = 0;
        doSingle(1, 1'b0, a, 32'h0, 4'hF, 0);

        // Reset in the middle of a BUSY transaction
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h2100_0000, 32'h0);
        @(negedge clk);
        checkOutput("rstb_busy_stb", rr_s.stb, 1'b1);
        #2 resetn = 1'b0;
        #1;
        checkOutput("rstb_stb_cyc", {rr_s.cyc, rr_s.stb}, 2'b00);
        checkOutput("rstb_grant", rr_grant, 2'b00);
        checkOutput("rstb_acks", {rr_ack, fp_ack}, 4'h0);
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstb_still_no_ack", rr_ack, 2'b00);
        resetn = 1'b1;
        resetModel();

        // The first contested grant after reset goes to m0
        doContested(2, 99);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
